// File: rtl/interp_pkg.sv
// Shared types and constants for the pixel interpolation blocks.
package interp_pkg;

  localparam int PIXEL_W = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ROW_A,
    ROW_B_PRE,
    ROW_B
  } upscale_state_t;

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port RAM holding one input row for the vertical replay.
// Synchronous write, synchronous read with one cycle of latency; the read
// data register holds its value whenever no read is issued.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array and read register; neither is reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/pixel_upscale.sv
// 2x nearest-neighbour upscaler. Each input pixel is emitted twice on the
// live row (ROW_A) while being stored in a line buffer; the stored row is
// then replayed, again doubling each pixel (ROW_B).
// Optional: define PIXEL_UPSCALE_EOL_EN to add o_eol, which flags the last
// pixel of every output row.
module pixel_upscale #(
  parameter int IN_WIDTH = 640,
  parameter int PIXEL_W  = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [PIXEL_W-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [PIXEL_W-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready
`ifdef PIXEL_UPSCALE_EOL_EN
  ,
  output logic               o_eol
`endif
);

  import interp_pkg::*;

  localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);

  upscale_state_t     state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               phase_q, phase_d;
  logic               valid_q, valid_d;
  logic [PIXEL_W-1:0] data_q, data_d;

  logic               out_xfer;
  logic               second_xfer;
  logic               in_xfer;
  logic               ready_raw;
  logic [COL_W-1:0]   col_next;
  logic               wr_en;
  logic               rd_en;
  logic [COL_W-1:0]   rd_addr;
  logic [PIXEL_W-1:0] rd_data;

  // Next-state logic: handshake decode, column/phase stepping and row switching.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    phase_d     = phase_q;
    valid_d     = valid_q;
    data_d      = data_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    out_xfer    = valid_q && i_ready;
    second_xfer = out_xfer && phase_q;
    col_next    = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
    ready_raw   = (state_q == ROW_A) &&
                  (!valid_q || (second_xfer && (col_q != LAST_COL)));
    o_ready     = i_rst_n && ready_raw;
    in_xfer     = i_valid && o_ready;

    unique case (state_q)
      ROW_A: begin
        if (out_xfer && !phase_q) begin
          phase_d = 1'b1;
        end
        if (second_xfer) begin
          phase_d = 1'b0;
          valid_d = 1'b0;
          col_d   = col_next;
          if (col_q == LAST_COL) begin
            state_d = ROW_B_PRE;
          end
        end
        if (in_xfer) begin
          data_d  = i_data;
          valid_d = 1'b1;
          phase_d = 1'b0;
          wr_en   = 1'b1;
        end
      end
      ROW_B_PRE: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        col_d   = '0;
        phase_d = 1'b0;
        valid_d = 1'b1;
        state_d = ROW_B;
      end
      ROW_B: begin
        if (out_xfer && !phase_q) begin
          phase_d = 1'b1;
        end
        if (second_xfer) begin
          phase_d = 1'b0;
          col_d   = col_next;
          if (col_q == LAST_COL) begin
            valid_d = 1'b0;
            state_d = ROW_A;
          end else begin
            rd_en   = 1'b1;
            rd_addr = col_next;
          end
        end
      end
      default: begin
        state_d = ROW_A;
      end
    endcase
  end

  // Control and hold registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ROW_A;
      col_q   <= '0;
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // The write lands at the column the held pixel will occupy (col_d already
  // accounts for a same-cycle release of the previous pixel).
  line_buffer #(
    .DEPTH (IN_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_line_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (col_d),
    .i_wr_data (i_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign o_valid = valid_q;
  assign o_data  = (state_q == ROW_B) ? rd_data : data_q;

`ifdef PIXEL_UPSCALE_EOL_EN
  logic eol_q, eol_d;

  // End-of-row flag follows the next output: second copy of the last column.
  always_comb begin
    eol_d = valid_d && phase_d && (col_d == LAST_COL);
  end

  // End-of-row register; moves only with the rest of the output state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      eol_q <= 1'b0;
    end else begin
      eol_q <= eol_d;
    end
  end

  assign o_eol = eol_q;
`endif

endmodule

// File: tb/tb_pixel_upscale.sv
// Bench for pixel_upscale with a short row. A queue-based reference model
// expands every accepted row into its doubled live and replayed outputs.
`timescale 1ns/1ps
module tb_pixel_upscale;

  localparam int IN_WIDTH = 4;
  localparam int PIXEL_W  = 12;
  localparam int ROW_OUT  = 4 * IN_WIDTH;

  typedef logic [PIXEL_W-1:0] row_t [IN_WIDTH];

  logic               i_clk   = 1'b0;
  logic               i_rst_n = 1'b0;
  logic [PIXEL_W-1:0] i_data  = '0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [PIXEL_W-1:0] o_data;
  logic               o_valid;
  logic               i_ready = 1'b1;
`ifdef PIXEL_UPSCALE_EOL_EN
  logic               o_eol;
  logic               prev_eol = 1'b0;
`endif

  int check_count     = 0;
  int fail_count      = 0;
  int cycle_count     = 0;
  int out_idx         = 0;
  int last_xfer_cycle = 0;
  bit stall_mode      = 1'b0;
  bit check_gaps      = 1'b0;
  bit prev_stall      = 1'b0;

  logic [PIXEL_W-1:0] exp_q [$];
  logic [PIXEL_W-1:0] row_buf [$];
  logic [PIXEL_W-1:0] prev_data = '0;
  logic [PIXEL_W-1:0] exp_pix;
  row_t               row_in;

  pixel_upscale #(
    .IN_WIDTH (IN_WIDTH),
    .PIXEL_W  (PIXEL_W)
  ) dut (
`ifdef PIXEL_UPSCALE_EOL_EN
    .o_eol   (o_eol),
`endif
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               tag, actual, expected, cycle_count);
    end
  endtask

  // Offers one row pixel by pixel, holding each until the DUT accepts it.
  task automatic applyStimulus(input row_t pix, input bit gaps);
    for (int p = 0; p < IN_WIDTH; p++) begin
      bit done = 1'b0;
      int waited = 0;
      if (gaps) begin
        i_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge i_clk);
          #1;
        end
      end
      i_valid = 1'b1;
      i_data  = pix[p];
      while (!done) begin
        @(negedge i_clk);
        if (o_ready) begin
          done = 1'b1;
        end else if (++waited > 300) begin
          checkOutput("accept_timeout", 32'(o_ready), 1);
          done = 1'b1;
        end
      end
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 600) begin
      @(negedge i_clk);
      waited++;
    end
    @(posedge i_clk);
    #1;
    checkOutput(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic waitOutIdx(input int target);
    int waited = 0;
    while (out_idx < target && waited < 600) begin
      @(negedge i_clk);
      waited++;
    end
    checkOutput("reach_out_idx", 32'(out_idx >= target), 1);
  endtask

  // Random downstream back-pressure when stall_mode is on.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge i_clk) begin
    cycle_count++;
    if (!i_rst_n) begin
      exp_q.delete();
      row_buf.delete();
      out_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(o_valid), 1);
        checkOutput("stall_data", 32'(o_data), 32'(prev_data));
`ifdef PIXEL_UPSCALE_EOL_EN
        checkOutput("stall_eol", 32'(o_eol), 32'(prev_eol));
`endif
      end
      if ((out_idx % ROW_OUT) >= 2 * IN_WIDTH) begin
        checkOutput("ready_in_replay", 32'(o_ready), 0);
      end
      if (i_valid && o_ready) begin
        row_buf.push_back(i_data);
        exp_q.push_back(i_data);
        exp_q.push_back(i_data);
        if (row_buf.size() == IN_WIDTH) begin
          foreach (row_buf[k]) begin
            exp_q.push_back(row_buf[k]);
            exp_q.push_back(row_buf[k]);
          end
          row_buf.delete();
        end
      end
      if (o_valid && i_ready) begin
        checkOutput("output_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_pix = exp_q.pop_front();
          checkOutput("data", 32'(o_data), 32'(exp_pix));
        end
`ifdef PIXEL_UPSCALE_EOL_EN
        checkOutput("eol", 32'(o_eol),
                    32'((out_idx % (2 * IN_WIDTH)) == 2 * IN_WIDTH - 1));
`endif
        if (check_gaps && (out_idx % ROW_OUT) != 0) begin
          checkOutput("xfer_gap", 32'(cycle_count - last_xfer_cycle),
                      ((out_idx % ROW_OUT) == 2 * IN_WIDTH) ? 2 : 1);
        end
        last_xfer_cycle = cycle_count;
        out_idx++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
`ifdef PIXEL_UPSCALE_EOL_EN
      prev_eol   = o_eol;
`endif
    end
  end

  // Hard stop in case something never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    #12;
    checkOutput("reset_valid", 32'(o_valid), 0);
    checkOutput("reset_data", 32'(o_data), 0);
    checkOutput("reset_ready", 32'(o_ready), 0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    checkOutput("release_ready", 32'(o_ready), 1);
    checkOutput("release_valid", 32'(o_valid), 0);
    checkOutput("release_data", 32'(o_data), 0);
    @(posedge i_clk);
    #1;

    $display("[TB] row 1,2,3,4 at full rate");
    check_gaps = 1'b1;
    row_in = '{12'd1, 12'd2, 12'd3, 12'd4};
    applyStimulus(row_in, 1'b0);
    waitDrain("drain_row_1234");

    $display("[TB] rows A then B back to back");
    row_in = '{12'd10, 12'd20, 12'd30, 12'd40};
    applyStimulus(row_in, 1'b0);
    row_in = '{12'd50, 12'd60, 12'd70, 12'd80};
    applyStimulus(row_in, 1'b0);
    waitDrain("drain_rows_ab");

    $display("[TB] random rows with back-pressure");
    check_gaps = 1'b0;
    stall_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < IN_WIDTH; p++) begin
        row_in[p] = PIXEL_W'($urandom);
      end
      applyStimulus(row_in, 1'b1);
    end
    waitDrain("drain_random");
    stall_mode = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("total_outputs", 32'(out_idx), 6 * ROW_OUT);
    checkOutput("idle_valid", 32'(o_valid), 0);

    $display("[TB] reset during replay");
    row_in = '{12'd100, 12'd200, 12'd300, 12'd400};
    applyStimulus(row_in, 1'b0);
    waitOutIdx(6 * ROW_OUT + 12);
    @(posedge i_clk);
    #2;
    checkOutput("pre_reset_valid", 32'(o_valid), 1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 32'(o_valid), 0);
    checkOutput("mid_reset_data", 32'(o_data), 0);
    checkOutput("mid_reset_ready", 32'(o_ready), 0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", 32'(o_ready), 1);
    @(posedge i_clk);
    #1;
    check_gaps = 1'b1;
    row_in = '{12'd5, 12'd6, 12'd7, 12'd8};
    applyStimulus(row_in, 1'b0);
    waitDrain("drain_after_reset");
    checkOutput("row_total", 32'(out_idx), ROW_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/pixel_upscale.md
Name: pixel_upscale

Overview:
- 2x nearest-neighbour upscaler for the 12-bit pixel stream. It is the inverse of the 2x2-averaging stage.
- Each input pixel becomes a 2x2 output block:
  - horizontally, by emitting the pixel twice;
  - vertically, by replaying the stored input row from an internal line buffer.
- Sits between the processed, downsampled stream and display/output logic.
- Valid/ready handshake on both sides.

Parameters:
- IN_WIDTH, 640, input pixels per row; output row = 2*IN_WIDTH pixels.
- PIXEL_W, 12, pixel bit width.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_data  input  PIXEL_W  input pixel
- i_valid  input  1  input pixel valid
- o_ready  output  1  block can accept input this cycle
- o_data  output  PIXEL_W  output pixel
- o_valid  output  1  output pixel valid
- i_ready  input  1  downstream accepts o_data this cycle

Behaviour:
- Reset, in any state or mid-row:
  - o_valid=0, o_data=0, o_ready=0 while asserted.
  - State=ROW_A, col=0, phase=0, hold empty.
  - Line-buffer contents undefined, and never read before being rewritten.
- Input transfer: i_valid && o_ready. Output transfer: o_valid && i_ready.
- States are ROW_A, ROW_B_PRE and ROW_B.
- ROW_A (live row):
  - o_ready = hold empty, OR (phase==1 && o_valid && i_ready). The second case gives full throughput of 1 input per 2 cycles.
  - On input transfer:
    - pixel goes into the hold register and is written to line_buffer[col];
    - o_valid=1 the next cycle with o_data=pixel, so latency is 1 cycle;
    - phase=0.
  - On output transfer with phase 0: phase becomes 1 and o_data is unchanged.
  - On output transfer with phase 1:
    - hold is released, phase becomes 0, col increments;
    - if no new input is accepted the same cycle, o_valid=0.
  - Phase-1 output transfer at col==IN_WIDTH-1: col=0, state becomes ROW_B_PRE, o_ready=0.
- ROW_B_PRE (one cycle):
  - Issues a synchronous read of address 0.
  - o_valid=0 and o_ready=0 in this state.
- ROW_B (replay):
  - o_ready=0 throughout.
  - o_data=line_buffer[col], o_valid=1; each pixel is emitted twice via phase.
  - The read of col+1 is issued on the phase-1 transfer, so there are no bubbles within the row.
  - Phase-1 transfer at col==IN_WIDTH-1: col=0, state becomes ROW_A, o_valid=0 the next cycle.
- Stall rule: while o_valid && !i_ready, o_data and o_valid are held stable and no counter advances.
- i_valid while o_ready=0 is ignored; upstream holds its data.
- Output per input row: exactly 4*IN_WIDTH pixels, namely 2*IN_WIDTH from live data followed by 2*IN_WIDTH from replay.
- col width = $clog2(IN_WIDTH). col never exceeds IN_WIDTH-1 and wraps to 0 only at row end.
- No frame tracking: rows alternate ROW_A/ROW_B indefinitely from reset.

Optional Feature:
- Macro: PIXEL_UPSCALE_EOL_EN.
- Defined:
  - adds output o_eol (1 bit), reset 0;
  - o_eol=1 coincident with o_valid on both phase-1 transfers at col==IN_WIDTH-1, i.e. the last pixel of each output row, in ROW_A and in ROW_B;
  - o_eol is held stable during stalls.
- Undefined: no o_eol port; behaviour otherwise identical.

Decomposition:
- Package interp_pkg:
  - PIXEL_W constant (12);
  - typedef pixel_t = logic [PIXEL_W-1:0];
  - typedef enum upscale_state_t {ROW_A, ROW_B_PRE, ROW_B}.
- Sub-module line_buffer:
  - simple dual-port RAM, DEPTH=IN_WIDTH, WIDTH=PIXEL_W;
  - synchronous write; synchronous read with 1-cycle latency;
  - no reset on the storage array.

Test Plan (IN_WIDTH=4):
- Reset release, i_valid=0 → o_valid=0, o_data=0; o_ready=1 on the first cycle after release.
- Row 1,2,3,4 streamed with i_ready=1 → output 1,1,2,2,3,3,4,4 then 1,1,2,2,3,3,4,4.
  - o_ready high every other cycle in ROW_A; exactly one bubble before the replay row; o_ready=0 during replay.
- Rows A=10,20,30,40 then B=50,60,70,80 → outputs are A doubled twice, then B doubled twice. B's values never leak into A's replay.
- Random i_ready stalls (50%) → data identical to the no-stall case; o_data stable across every stalled cycle; total of 16 outputs per row.
- Assert reset mid-replay at col=2 → o_valid drops immediately. After release: state=ROW_A, o_ready=1, and the next row 5,6,7,8 emits correctly from col 0.
- With PIXEL_UPSCALE_EOL_EN → o_eol=1 only on output indices 7 and 15 of each 16-pixel group. Without the macro, the bench compiles without the o_eol port.
